ascii_time_parser: RTL and testbench

- Receive-side counterpart of the time-to-ASCII serializer. Parses a byte stream popped from the UART RX FIFO and recognises time-set frames of the form `[spaces]TIME:HH:MM:SS<LF|CR>`.
- On a complete, range-valid frame it updates a 24-bit packed-BCD time word (HH:MM:SS) for the clock core and pulses a set strobe.
- Malformed, out-of-range or stalled frames are discarded and flagged. time_data is never partially updated.

---
 rtl/ascii_time_parser.sv | 168 ++++++++++++++++
 tb/tb_ascii_time_parser.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_time_parser.sv
// ascii_time_parser: recognises "[spaces]TIME:HH:MM:SS<LF|CR>" frames on a
// byte stream and loads a packed-BCD time word on each complete, in-range
// frame. Rejected or stalled frames raise a single cmd_err pulse and leave
// time_data untouched.
module ascii_time_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [23:0] time_data,
    output logic        time_set,
    output logic        cmd_err,
    output logic        busy
);

    // Counter only needs to reach TIMEOUT_CYCLES-1: the timeout fires on the
    // edge that would have made it TIMEOUT_CYCLES.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_COL = 8'h3A;
    localparam logic [7:0] CH_T   = 8'h54;
    localparam logic [7:0] CH_I   = 8'h49;
    localparam logic [7:0] CH_M   = 8'h4D;
    localparam logic [7:0] CH_E   = 8'h45;

    // G_T is kept in the encoding for symmetry with the frame layout; IDLE
    // itself consumes the 'T', so G_T is never entered.
    typedef enum logic [3:0] {
        IDLE, G_T, G_I, G_M, G_E, G_COL1, G_H10, G_H1, G_COL2,
        G_M10, G_M1, G_COL3, G_S10, G_S1, G_EOL, ERR
    } state_t;

    state_t           state_q, state_d;
    logic [23:0]      buf_q, buf_d;
    logic [23:0]      time_data_q, time_data_d;
    logic             time_set_q, time_set_d;
    logic             cmd_err_q, cmd_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       is_eol;
    logic       is_dig;
    logic [3:0] dig_val;
    logic       timeout_hit;
    logic       accept;
    logic       reject;

    assign is_eol  = (rx_data == CH_LF) || (rx_data == CH_CR);
    assign is_dig  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign dig_val = rx_data[3:0];
    assign timeout_hit = TIMEOUT_EN && (state_q != IDLE) && !rx_valid && (cnt_q == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            buf_q       <= 24'h000000;
            time_data_q <= 24'h000000;
            time_set_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            time_data_q <= time_data_d;
            time_set_q  <= time_set_d;
            cmd_err_q   <= cmd_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state: frame grammar, digit ranges, commit, and inter-byte timeout
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        time_data_d = time_data_q;
        time_set_d  = 1'b0;
        cmd_err_d   = 1'b0;
        accept      = 1'b0;
        reject      = 1'b0;
        cnt_d       = (rx_valid || state_q == IDLE || timeout_hit) ? '0 : cnt_q + CNT_W'(1);

        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == CH_T) begin
                        state_d = G_I;
                    end else if (!(is_eol || rx_data == CH_SP)) begin
                        reject = 1'b1;
                    end
                end
                ERR: begin
                    if (is_eol) begin
                        state_d = IDLE;
                    end
                end
                G_EOL: begin
                    if (is_eol) begin
                        state_d     = IDLE;
                        time_data_d = buf_q;
                        time_set_d  = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: begin
                    if (is_eol) begin
                        // Terminator already consumed, so skip ERR entirely
                        state_d   = IDLE;
                        cmd_err_d = 1'b1;
                    end else begin
                        case (state_q)
                            G_I:    if (rx_data == CH_I)   begin accept = 1'b1; state_d = G_M;    end
                            G_M:    if (rx_data == CH_M)   begin accept = 1'b1; state_d = G_E;    end
                            G_E:    if (rx_data == CH_E)   begin accept = 1'b1; state_d = G_COL1; end
                            G_COL1: if (rx_data == CH_COL) begin accept = 1'b1; state_d = G_H10;  end
                            G_H10: if (is_dig && dig_val <= 4'd2) begin
                                accept = 1'b1; state_d = G_H1; buf_d[23:20] = dig_val;
                            end
                            G_H1: if (is_dig && (buf_q[23:20] != 4'd2 || dig_val <= 4'd3)) begin
                                accept = 1'b1; state_d = G_COL2; buf_d[19:16] = dig_val;
                            end
                            G_COL2: if (rx_data == CH_COL) begin accept = 1'b1; state_d = G_M10; end
                            G_M10: if (is_dig && dig_val <= 4'd5) begin
                                accept = 1'b1; state_d = G_M1; buf_d[15:12] = dig_val;
                            end
                            G_M1: if (is_dig) begin
                                accept = 1'b1; state_d = G_COL3; buf_d[11:8] = dig_val;
                            end
                            G_COL3: if (rx_data == CH_COL) begin accept = 1'b1; state_d = G_S10; end
                            G_S10: if (is_dig && dig_val <= 4'd5) begin
                                accept = 1'b1; state_d = G_S1; buf_d[7:4] = dig_val;
                            end
                            G_S1: if (is_dig) begin
                                accept = 1'b1; state_d = G_EOL; buf_d[3:0] = dig_val;
                            end
                            default: accept = 1'b0;
                        endcase
                        reject = !accept;
                    end
                end
            endcase
            if (reject) begin
                state_d   = ERR;
                cmd_err_d = 1'b1;
            end
        end else if (timeout_hit) begin
            // A stall inside ERR was already reported; just resynchronise
            state_d   = IDLE;
            cmd_err_d = (state_q != ERR);
        end
    end

    // Outputs
    always_comb begin
        busy      = (state_q != IDLE);
        time_data = time_data_q;
        time_set  = time_set_q;
        cmd_err   = cmd_err_q;
    end

endmodule

// File: tb/tb_ascii_time_parser.sv
// Scoreboard bench for ascii_time_parser: a string-level frame model predicts
// every time_set / cmd_err pulse (kind, cycle, time_data) and a monitor
// checks each pulse the DUT produces against the queue.
module tb_ascii_time_parser;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [23:0] time_data;
    logic        time_set;
    logic        cmd_err;
    logic        busy;

    ascii_time_parser #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .time_data(time_data), .time_set(time_set), .cmd_err(cmd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(bit ok, string name, string act, string req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit          is_set;
        logic [23:0] val;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    string       cur = "";
    bit          in_err = 1'b0;
    int          last_c = 0;
    logic [23:0] exp_td = 24'h0;

    function automatic void push(bit is_set, logic [23:0] v, int c);
        exp_t e;
        e.is_set = is_set;
        e.val = v;
        e.cyc = c;
        q.push_back(e);
        $display("expect %s at cycle %0d time_data=%06h", is_set ? "time_set" : "cmd_err", c, v);
    endfunction

    // Is s a legal prefix of "TIME:HH:MM:SS" with hour<=23, min/sec<=59?
    function automatic bit prefix_ok(string s);
        string tmpl;
        int d;
        tmpl = "TIME:##:##:##";
        if (s.len() > 13) return 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            if (tmpl[i] == 8'h23) begin
                d = int'(s[i]) - 48;
                if (d < 0 || d > 9) return 1'b0;
                if (i == 5 && d > 2) return 1'b0;
                if (i == 6 && s[5] == 8'h32 && d > 3) return 1'b0;
                if ((i == 8 || i == 11) && d > 5) return 1'b0;
            end else if (s[i] != tmpl[i]) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    // No byte arrives on any edge up to and including edge t
    function automatic void model_quiet(int t);
        if ((cur.len() > 0 || in_err) && t >= last_c + TO) begin
            if (!in_err) push(1'b0, exp_td, last_c + TO);
            cur = "";
            in_err = 1'b0;
        end
    endfunction

    function automatic void model_byte(byte b, int c);
        bit eol;
        string one;
        logic [23:0] v;
        byte dg;
        int pos[6] = '{5, 6, 8, 9, 11, 12};
        model_quiet(c - 1);
        last_c = c;
        eol = (b == 8'h0A) || (b == 8'h0D);
        if (in_err) begin
            if (eol) in_err = 1'b0;
            return;
        end
        if (cur.len() == 0 && (b == 8'h20 || eol)) return;
        if (eol) begin
            if (cur.len() == 13) begin
                v = 24'h0;
                for (int k = 0; k < 6; k++) begin
                    dg = cur[pos[k]] - 8'h30;
                    v = {v[19:0], dg[3:0]};
                end
                exp_td = v;
                push(1'b1, v, c);
            end else begin
                push(1'b0, exp_td, c);
            end
            cur = "";
            return;
        end
        one = " ";
        one[0] = b;
        cur = {cur, one};
        if (!prefix_ok(cur)) begin
            push(1'b0, exp_td, c);
            in_err = 1'b1;
            cur = "";
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (time_set || cmd_err) begin
                chk(!(time_set && cmd_err), "pulse_exclusive", $sformatf("set=%0b err=%0b", time_set, cmd_err), "not both");
                chk(q.size() != 0, "unexpected_pulse", $sformatf("set=%0b err=%0b", time_set, cmd_err), "no pulse");
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk(e.is_set == time_set, "pulse_kind", $sformatf("set=%0b", time_set), $sformatf("set=%0b", e.is_set));
                    chk(e.cyc == cyc, "pulse_cycle", $sformatf("%0d", cyc), $sformatf("%0d", e.cyc));
                    chk(time_data == e.val, "time_data", $sformatf("%06h", time_data), $sformatf("%06h", e.val));
                    $display("pulse %s cycle %0d time_data=%06h", time_set ? "time_set" : "cmd_err", cyc, time_data);
                end
            end else if (q.size() != 0) begin
                chk(q[0].cyc > cyc, "missed_pulse", "none", $sformatf("pulse at cycle %0d", q[0].cyc));
                if (q[0].cyc <= cyc) void'(q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input byte b, input int gap);
        int g;
        g = (gap <= 0) ? int'($urandom_range(1, 4)) : gap;
        model_byte(b, cyc + 1);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
        repeat (g - 1) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send(s[i], gap);
    endtask

    task automatic stall(input int n);
        model_quiet(cyc + n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_val(input logic [23:0] req, input string name);
        chk(time_data === req, name, $sformatf("%06h", time_data), $sformatf("%06h", req));
    endtask

    task automatic check_busy(input bit req, input string name);
        chk(busy === req, name, $sformatf("%0b", busy), $sformatf("%0b", req));
    endtask

    function automatic string make_frame();
        string s, pre, term;
        int mode, p;
        pre = "";
        repeat ($urandom_range(0, 2)) pre = {pre, " "};
        s = $sformatf("TIME:%02d:%02d:%02d", $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
        mode = $urandom_range(0, 5);
        case (mode)
            2: begin
                p = $urandom_range(0, 3);
                if (p == 0) s[5] = 8'(8'h33 + $urandom_range(0, 6));
                else if (p == 1) begin s[5] = 8'h32; s[6] = 8'(8'h34 + $urandom_range(0, 5)); end
                else if (p == 2) s[8] = 8'(8'h36 + $urandom_range(0, 3));
                else s[11] = 8'(8'h36 + $urandom_range(0, 3));
            end
            3: s[$urandom_range(0, 12)] = 8'($urandom_range(1, 255));
            4: s = s.substr(0, $urandom_range(0, 11));
            5: s[$urandom_range(0, 3)] = 8'h78;
            default: ;
        endcase
        term = ($urandom_range(0, 1) != 0) ? "\n" : "\r";
        return {pre, s, term};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(negedge clk);
        check_val(24'h000000, "reset_time_data");
        chk(time_set === 1'b0, "reset_time_set", $sformatf("%0b", time_set), "0");
        chk(cmd_err === 1'b0, "reset_cmd_err", $sformatf("%0b", cmd_err), "0");
        check_busy(1'b0, "reset_busy");
        rst = 1'b1;
        @(negedge clk);

        // valid frame, one byte every 3 cycles
        send_str(" TIME:12:34:56\n", 3);
        check_val(24'h123456, "valid_frame");
        check_busy(1'b0, "busy_after_valid");
        stall(5);

        // back-to-back frames with rx_valid held high
        send_str("TIME:23:59:59\rTIME:00:00:00\n", 1);
        check_val(24'h000000, "back_to_back");
        stall(3);

        // range errors then a good frame
        send_str("TIME:24:00:00\n", 2);
        send_str("TIME:12:60:00\n", 2);
        check_val(24'h000000, "range_err_unchanged");
        send_str("TIME:01:02:03\n", 1);
        check_val(24'h010203, "after_range_err");

        // bad character and early terminator
        send_str("TIMX:12:34:56\n", 2);
        check_busy(1'b0, "busy_after_bad_char");
        send_str("TIME:12\n", 2);
        check_busy(1'b0, "busy_after_early_eol");
        check_val(24'h010203, "bad_frames_unchanged");

        // timeout then a normal frame
        send_str("TIME:1", 2);
        stall(80);
        check_busy(1'b0, "busy_after_timeout");
        send_str("TIME:11:22:33\n", 1);
        check_val(24'h112233, "after_timeout");

        // asynchronous reset mid-frame
        send_str("TIME:12:34:56\n", 1);
        send_str("TIME:09:", 1);
        check_busy(1'b1, "busy_mid_frame");
        #2 rst = 1'b0;
        #1;
        check_val(24'h000000, "async_reset_time_data");
        check_busy(1'b0, "async_reset_busy");
        chk(q.size() == 0, "queue_at_reset", $sformatf("%0d", q.size()), "0");
        cur = "";
        in_err = 1'b0;
        exp_td = 24'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_str("TIME:09:08:07\n", 3);
        check_val(24'h090807, "after_reset_frame");

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            send_str(make_frame(), 0);
            if ($urandom_range(0, 3) == 0) stall($urandom_range(1, 6));
        end

        stall(60);
        chk(q.size() == 0, "queue_drained", $sformatf("%0d", q.size()), "0");
        check_val(exp_td, "final_time_data");
        check_busy(1'b0, "final_busy");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
